apb_master_int: RTL and testbench

APB4 requester engine for the AXI4Lite-to-APB4 bridge. It accepts one command at a time from the bridge front end over a valid/ready interface and runs the APB4 SETUP/ACCESS sequence toward the slave, including wait states. It returns read data, slave error and timeout status on a valid/ready response channel. It drives the same PSELx/PENABLE/PADDR bus that the config/status slave interfaces decode.

---
 rtl/apb_master_int.sv | 124 ++++++++++++
 tb/tb_apb_master_int.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/apb_master_int.sv
// APB4 requester engine: takes one command at a time, runs SETUP/ACCESS with
// wait states and an optional timeout, and returns the result on a response channel.
module apb_master_int #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 8
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_wstrb,
    input  logic [2:0]  cmd_prot,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_slverr,
    output logic        rsp_timeout,
    output logic        PSELx,
    output logic        PENABLE,
    output logic [31:0] PADDR,
    output logic        PWRITE,
    output logic [31:0] PWDATA,
    output logic [3:0]  PSTRB,
    output logic [2:0]  PPROT,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    // The counter holds the number of wait cycles already elapsed, so the
    // abort fires on the ACCESS cycle where cnt_r is one short of the limit.
    localparam logic             TO_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    logic [1:0]       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             timeout_hit_s;

    assign timeout_hit_s = TO_EN && (cnt_r == CNT_LAST);
    assign cmd_ready     = (state_r == IDLE);

    // APB sequencing, response capture and timeout counting
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            PSELx       <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= 32'd0;
            PWDATA      <= 32'd0;
            PSTRB       <= 4'd0;
            PPROT       <= 3'd0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= 32'd0;
            rsp_slverr  <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (cmd_valid) begin
                        PADDR   <= cmd_addr;
                        PWRITE  <= cmd_write;
                        PWDATA  <= cmd_wdata;
                        PSTRB   <= cmd_write ? cmd_wstrb : 4'b0000;
                        PPROT   <= cmd_prot;
                        PSELx   <= 1'b1;
                        PENABLE <= 1'b0;
                        state_r <= SETUP;
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    state_r <= ACCESS;
                end
                ACCESS: begin
                    if (PREADY) begin
                        PSELx       <= 1'b0;
                        PENABLE     <= 1'b0;
                        rsp_rdata   <= PWRITE ? 32'd0 : PRDATA;
                        rsp_slverr  <= PSLVERR;
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= 1'b1;
                        state_r     <= RESP;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                        if (timeout_hit_s) begin
                            PSELx       <= 1'b0;
                            PENABLE     <= 1'b0;
                            rsp_rdata   <= 32'd0;
                            rsp_slverr  <= 1'b1;
                            rsp_timeout <= 1'b1;
                            rsp_valid   <= 1'b1;
                            state_r     <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cnt_r     <= '0;
                        state_r   <= IDLE;
                    end
                end
                default: begin
                    PSELx     <= 1'b0;
                    PENABLE   <= 1'b0;
                    rsp_valid <= 1'b0;
                    cnt_r     <= '0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_int.sv
// Directed testbench for apb_master_int with a response scoreboard.
module tb_apb_master_int;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic [2:0]  cmd_prot;
    logic        rsp_valid, rsp_ready, rsp_slverr, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic        PSELx, PENABLE, PWRITE, PREADY, PSLVERR;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic [3:0]  PSTRB;
    logic [2:0]  PPROT;

    int checks = 0;
    int errors = 0;
    logic [33:0] sb[$];

    apb_master_int #(.TIMEOUT_CYCLES(16), .CNT_W(8)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb), .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout),
        .PSELx(PSELx), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    task automatic tick;
        @(posedge PCLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_psel"},    32'(PSELx),       32'd0);
        check({tag, "_penable"}, 32'(PENABLE),     32'd0);
        check({tag, "_pwrite"},  32'(PWRITE),      32'd0);
        check({tag, "_paddr"},   PADDR,            32'd0);
        check({tag, "_pwdata"},  PWDATA,           32'd0);
        check({tag, "_pstrb"},   32'(PSTRB),       32'd0);
        check({tag, "_pprot"},   32'(PPROT),       32'd0);
        check({tag, "_rvalid"},  32'(rsp_valid),   32'd0);
        check({tag, "_rdata"},   rsp_rdata,        32'd0);
        check({tag, "_slverr"},  32'(rsp_slverr),  32'd0);
        check({tag, "_tmo"},     32'(rsp_timeout), 32'd0);
        check({tag, "_cready"},  32'(cmd_ready),   32'd1);
    endtask

    // acc: ACCESS cycles to run; rdy_last: PREADY on the last one (else timeout expected)
    task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input logic [2:0] prot, input int acc,
                       input logic rdy_last, input logic [31:0] rdata, input logic serr,
                       input int hold);
        logic [31:0] exp_strb;
        logic [33:0] e;
        exp_strb = wr ? {28'd0, strb} : 32'd0;
        if (rdy_last) sb.push_back({1'b0, serr, (wr ? 32'd0 : rdata)});
        else          sb.push_back({1'b1, 1'b1, 32'd0});

        check("idle_cmd_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
        cmd_wstrb = strb; cmd_prot = prot;
        tick;
        cmd_valid = 1'b0; cmd_addr = ~addr; cmd_wdata = ~wdata; cmd_wstrb = ~strb;
        cmd_prot = ~prot; cmd_write = ~wr;

        check("setup_psel",    32'(PSELx),     32'd1);
        check("setup_penable", 32'(PENABLE),   32'd0);
        check("setup_paddr",   PADDR,          addr);
        check("setup_pwrite",  32'(PWRITE),    32'(wr));
        check("setup_pwdata",  PWDATA,         wdata);
        check("setup_pstrb",   32'(PSTRB),     exp_strb);
        check("setup_pprot",   32'(PPROT),     32'(prot));
        check("setup_cready",  32'(cmd_ready), 32'd0);
        tick;

        for (int i = 0; i < acc; i++) begin
            check("access_psel",    32'(PSELx),     32'd1);
            check("access_penable", 32'(PENABLE),   32'd1);
            check("access_paddr",   PADDR,          addr);
            check("access_pwdata",  PWDATA,         wdata);
            check("access_pstrb",   32'(PSTRB),     exp_strb);
            check("access_rvalid",  32'(rsp_valid), 32'd0);
            PREADY  = (i == acc - 1) && rdy_last;
            PRDATA  = PREADY ? rdata : ~rdata;
            PSLVERR = PREADY ? serr : ~serr;
            tick;
        end
        PREADY = 1'b0; PRDATA = 32'hA5A5_A5A5; PSLVERR = 1'b1;

        check("resp_psel",    32'(PSELx),     32'd0);
        check("resp_penable", 32'(PENABLE),   32'd0);
        check("resp_rvalid",  32'(rsp_valid), 32'd1);
        check("resp_paddr",   PADDR,          addr);
        check("resp_cready",  32'(cmd_ready), 32'd0);
        e = sb.pop_front();

        for (int h = 0; h < hold; h++) begin
            cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'hFFFF_0000;
            check("bp_rvalid", 32'(rsp_valid),   32'd1);
            check("bp_rdata",  rsp_rdata,        e[31:0]);
            check("bp_slverr", 32'(rsp_slverr),  32'(e[32]));
            check("bp_tmo",    32'(rsp_timeout), 32'(e[33]));
            check("bp_cready", 32'(cmd_ready),   32'd0);
            check("bp_psel",   32'(PSELx),       32'd0);
            tick;
        end
        cmd_valid = 1'b0;

        rsp_ready = 1'b1;
        check("rsp_rdata",  rsp_rdata,        e[31:0]);
        check("rsp_slverr", 32'(rsp_slverr),  32'(e[32]));
        check("rsp_tmo",    32'(rsp_timeout), 32'(e[33]));
        tick;
        rsp_ready = 1'b0;
        check("post_rvalid", 32'(rsp_valid), 32'd0);
        check("post_cready", 32'(cmd_ready), 32'd1);
        check("post_psel",   32'(PSELx),     32'd0);
    endtask

    initial begin
        PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'd0;
        cmd_wdata = 32'd0; cmd_wstrb = 4'd0; cmd_prot = 3'd0; rsp_ready = 1'b0;
        PRDATA = 32'd0; PREADY = 1'b0; PSLVERR = 1'b0;
        tick;
        tick;
        PRESET = 1'b0;
        check_reset_outputs("reset");

        // zero-wait write
        txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 3'b000, 1, 1'b1, 32'h0, 1'b0, 0);
        // read with 3 wait states; strobes offered on a read must not reach PSTRB
        txn(1'b0, 32'h0000_0020, 32'h0, 4'hF, 3'b010, 4, 1'b1, 32'h1234_5678, 1'b0, 0);
        // slave error on a write
        txn(1'b1, 32'h0000_0030, 32'hCAFE_F00D, 4'h3, 3'b001, 1, 1'b1, 32'h0, 1'b1, 0);
        // timeout after 16 ACCESS cycles
        txn(1'b0, 32'h0000_0044, 32'h0, 4'h0, 3'b111, 16, 1'b0, 32'h55AA_55AA, 1'b0, 0);
        // PREADY on the 16th ACCESS cycle beats the timeout
        txn(1'b0, 32'h0000_0048, 32'h0, 4'h0, 3'b000, 16, 1'b1, 32'h0BAD_F00D, 1'b0, 0);
        // response backpressure with a pending command
        txn(1'b1, 32'h0000_0050, 32'h1122_3344, 4'hC, 3'b100, 2, 1'b1, 32'h0, 1'b0, 5);

        // reset asserted while a read waits in ACCESS
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0060; cmd_prot = 3'b011;
        tick;
        cmd_valid = 1'b0;
        tick;
        tick;
        check("pre_rst_penable", 32'(PENABLE), 32'd1);
        PRESET = 1'b1;
        tick;
        PRESET = 1'b0;
        check_reset_outputs("mid_rst");
        tick;
        tick;
        check("mid_rst_norsp", 32'(rsp_valid), 32'd0);
        check("mid_rst_nosel", 32'(PSELx),     32'd0);

        // recovery transfer
        txn(1'b0, 32'h0000_0064, 32'h0, 4'h0, 3'b000, 2, 1'b1, 32'h8765_4321, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
